psr_n: RTL

//  Parametrised parallel/serial shift register; successor to the fixed 2-stage psr cell.
//  - Shifts serial data in on sin and out on sout.
//  - Counts bits per frame; publishes each complete frame on pout with a one-cycle frame_vld strobe.
//  - Supports parallel preload (load/pin) so the same block serves as serialiser and deserialiser.

---
 rtl/psr_n.sv | 81 ++++++++
 1 files changed

// File: rtl/psr_n.sv
// Parametrised parallel/serial shift register with frame counting and a holding register.
// Optional `PSR_PARITY_EN adds pout_par, the parity of each published frame.
module psr_n #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned FRAME_LEN = 8,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             sin,
   input  logic             shift_en,
   input  logic             load,
   input  logic [WIDTH-1:0] pin,
   output logic             sout,
   output logic [WIDTH-1:0] pout,
   output logic             frame_vld,
   output logic             busy
`ifdef PSR_PARITY_EN
   ,
   output logic             pout_par
`endif
);

   localparam int unsigned CW = $clog2(FRAME_LEN + 1);
   localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

   if (WIDTH < 2 || FRAME_LEN < 1 || FRAME_LEN > WIDTH) begin : g_bad_param
      $error("psr_n: need WIDTH>=2 and 1<=FRAME_LEN<=WIDTH");
   end

   logic [WIDTH-1:0] sreg;
   logic [WIDTH-1:0] sreg_nxt;
   logic [CW-1:0]    cnt;
   logic             frame_done;

   always_comb begin
      sreg_nxt = MSB_FIRST ? {sreg[WIDTH-2:0], sin} : {sin, sreg[WIDTH-1:1]};
   end

   // A frame completes on the shift that brings the count to FRAME_LEN; load takes precedence.
   assign frame_done = !load && shift_en && (cnt == LAST);

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         sreg      <= '0;
         cnt       <= '0;
         pout      <= '0;
         frame_vld <= 1'b0;
      end else if (load) begin
         sreg      <= pin;
         cnt       <= '0;
         frame_vld <= 1'b0;
      end else if (shift_en) begin
         sreg <= sreg_nxt;
         if (frame_done) begin
            cnt       <= '0;
            pout      <= sreg_nxt;
            frame_vld <= 1'b1;
         end else begin
            cnt       <= cnt + CW'(1);
            frame_vld <= 1'b0;
         end
      end else begin
         frame_vld <= 1'b0;
      end
   end

`ifdef PSR_PARITY_EN
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         pout_par <= 1'b0;
      end else if (frame_done) begin
         pout_par <= ^sreg_nxt;
      end
   end
`endif

   assign sout = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
   assign busy = (cnt != '0);

endmodule
